lcd_bus_driver: RTL and testbench



---
 rtl/lcd_bus_driver_if.sv | 22 ++
 rtl/lcd_bus_driver.sv | 189 ++++++++++++++++++
 tb/tb_lcd_bus_driver.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_driver_if.sv
// Byte-write handshake between the core's LCD register logic and the LCD bus driver.
// Valid/ready: a byte transfers on a rising edge where i_wr_valid and o_wr_ready are both 1; the requester holds valid and payload until then.
interface lcd_bus_driver_if;
  logic       i_wr_valid;
  logic       i_wr_rs;
  logic [7:0] i_wr_data;
  logic       o_wr_ready;

  modport slave (
    input  i_wr_valid,
    input  i_wr_rs,
    input  i_wr_data,
    output o_wr_ready
  );

  modport master (
    output i_wr_valid,
    output i_wr_rs,
    output i_wr_data,
    input  o_wr_ready
  );
endinterface

// File: rtl/lcd_bus_driver.sv
// HD44780-style LCD bus driver: power-up wait, fixed init sequence, then one byte per
// handshake with setup / EN pulse / hold / execution-wait timing. All outputs registered.
module lcd_bus_driver #(
  parameter int unsigned PWRUP_CYC    = 750000,
  parameter int unsigned SETUP_CYC    = 2,
  parameter int unsigned EN_HIGH_CYC  = 25,
  parameter int unsigned HOLD_CYC     = 2,
  parameter int unsigned CMD_WAIT_CYC = 2000,
  parameter int unsigned CLR_WAIT_CYC = 82000
) (
  input  logic                i_clk,
  input  logic                i_reset,
  lcd_bus_driver_if.slave     wr,
  output logic                o_init_done,
  output logic [7:0]          o_lcd_data,
  output logic                o_lcd_rs,
  output logic                o_lcd_rw,
  output logic                o_lcd_en,
  output logic                o_lcd_on,
  output logic [2:0]          o_dbg_state
);

  if (PWRUP_CYC < 1 || SETUP_CYC < 1 || EN_HIGH_CYC < 1 || HOLD_CYC < 1 ||
      CMD_WAIT_CYC < 1 || CLR_WAIT_CYC < 1) begin : g_param_check
    $error("lcd_bus_driver: every timing parameter must be at least 1");
  end

  typedef enum logic [2:0] {
    S_PWRUP = 3'd0,
    S_SETUP = 3'd1,
    S_EN_HI = 3'd2,
    S_HOLD  = 3'd3,
    S_WAIT  = 3'd4,
    S_IDLE  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_next;
  logic [1:0]  r_init_idx;
  logic [1:0]  w_init_idx_next;
  logic        r_wr_ready;
  logic        r_init_done;
  logic        w_init_done_next;
  logic [7:0]  r_lcd_data;
  logic [7:0]  w_lcd_data_next;
  logic        r_lcd_rs;
  logic        w_lcd_rs_next;
  logic        r_lcd_rw;
  logic        r_lcd_en;
  logic        r_lcd_on;
  logic        w_last;
  logic        w_is_clear;
  logic [31:0] w_wait_cyc;

  function automatic logic [7:0] f_init_byte(input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h01;
      default: b = 8'h06;
    endcase
    return b;
  endfunction

  function automatic logic [31:0] f_load(input state_t s, input logic [31:0] wait_cyc);
    logic [31:0] v;
    unique case (s)
      S_PWRUP: v = 32'(PWRUP_CYC);
      S_SETUP: v = 32'(SETUP_CYC);
      S_EN_HI: v = 32'(EN_HIGH_CYC);
      S_HOLD:  v = 32'(HOLD_CYC);
      S_WAIT:  v = wait_cyc;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  // Clear and home need the long execution wait; only commands qualify, never data bytes.
  assign w_is_clear = !r_lcd_rs && (r_lcd_data == 8'h01 || r_lcd_data == 8'h02 ||
                                    r_lcd_data == 8'h03);
  assign w_wait_cyc = w_is_clear ? 32'(CLR_WAIT_CYC) : 32'(CMD_WAIT_CYC);

  // Reset leaves the counter at 0, so the first power-up cycle arms it with one cycle already spent.
  always_comb begin
    w_last = 1'b0;
    if (r_state == S_PWRUP && r_cnt == 32'd0) begin
      w_last = (PWRUP_CYC == 1);
    end else begin
      w_last = (r_cnt == 32'd1);
    end
  end

  always_comb begin
    w_next           = r_state;
    w_cnt_next       = (r_cnt != 32'd0) ? r_cnt - 32'd1 : 32'd0;
    w_init_idx_next  = r_init_idx;
    w_init_done_next = r_init_done;
    w_lcd_data_next  = r_lcd_data;
    w_lcd_rs_next    = r_lcd_rs;

    unique case (r_state)
      S_PWRUP: begin
        if (w_last) begin
          w_next          = S_SETUP;
          w_init_idx_next = 2'd0;
          w_lcd_data_next = f_init_byte(2'd0);
          w_lcd_rs_next   = 1'b0;
        end else if (r_cnt == 32'd0) begin
          w_cnt_next = 32'(PWRUP_CYC - 1);
        end
      end
      S_SETUP: begin
        if (w_last) w_next = S_EN_HI;
      end
      S_EN_HI: begin
        if (w_last) w_next = S_HOLD;
      end
      S_HOLD: begin
        if (w_last) w_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_last) begin
          if (!r_init_done && r_init_idx != 2'd3) begin
            w_next          = S_SETUP;
            w_init_idx_next = r_init_idx + 2'd1;
            w_lcd_data_next = f_init_byte(r_init_idx + 2'd1);
            w_lcd_rs_next   = 1'b0;
          end else begin
            w_next           = S_IDLE;
            w_init_done_next = 1'b1;
          end
        end
      end
      S_IDLE: begin
        if (wr.i_wr_valid) begin
          w_next          = S_SETUP;
          w_lcd_data_next = wr.i_wr_data;
          w_lcd_rs_next   = wr.i_wr_rs;
        end
      end
      default: begin
        w_next = S_PWRUP;
      end
    endcase

    if (w_next != r_state) begin
      w_cnt_next = f_load(w_next, w_wait_cyc);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_PWRUP;
      r_cnt       <= 32'd0;
      r_init_idx  <= 2'd0;
      r_wr_ready  <= 1'b0;
      r_init_done <= 1'b0;
      r_lcd_data  <= 8'h00;
      r_lcd_rs    <= 1'b0;
      r_lcd_rw    <= 1'b0;
      r_lcd_en    <= 1'b0;
      r_lcd_on    <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_init_idx  <= w_init_idx_next;
      r_wr_ready  <= (w_next == S_IDLE);
      r_init_done <= w_init_done_next;
      r_lcd_data  <= w_lcd_data_next;
      r_lcd_rs    <= w_lcd_rs_next;
      r_lcd_rw    <= 1'b0;
      r_lcd_en    <= (w_next == S_EN_HI);
      r_lcd_on    <= 1'b1;
    end
  end

  assign wr.o_wr_ready = r_wr_ready;
  assign o_init_done   = r_init_done;
  assign o_lcd_data    = r_lcd_data;
  assign o_lcd_rs      = r_lcd_rs;
  assign o_lcd_rw      = r_lcd_rw;
  assign o_lcd_en      = r_lcd_en;
  assign o_lcd_on      = r_lcd_on;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Directed bench for lcd_bus_driver with short timing parameters: init-sequence table,
// write table with latency per byte, back-to-back writes, valid during init, reset with EN high.
module tb_lcd_bus_driver;

  logic       clk;
  logic       rst;
  logic       init_done;
  logic [7:0] lcd_data;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_en;
  logic       lcd_on;
  logic [2:0] dbg_state;

  int n_checks;
  int n_errors;

  lcd_bus_driver_if wr_if ();

  lcd_bus_driver #(
    .PWRUP_CYC   (8),
    .SETUP_CYC   (1),
    .EN_HIGH_CYC (2),
    .HOLD_CYC    (1),
    .CMD_WAIT_CYC(4),
    .CLR_WAIT_CYC(10)
  ) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .wr         (wr_if),
    .o_init_done(init_done),
    .o_lcd_data (lcd_data),
    .o_lcd_rs   (lcd_rs),
    .o_lcd_rw   (lcd_rw),
    .o_lcd_en   (lcd_en),
    .o_lcd_on   (lcd_on),
    .o_dbg_state(dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    int         cyc;
    logic       en;
    logic [7:0] data;
    logic       rs;
    logic       rdy;
    logic       done;
    logic       on;
  } init_vec_t;

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         lat;
  } wr_vec_t;

  init_vec_t init_tbl[$];
  wr_vec_t   wr_tbl[$];
  logic [7:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called in cycle 0 (first cycle with reset low); returns in cycle 46.
  task automatic run_init(input bit valid_at_20);
    int ti;
    int en_cnt;
    int rw_bad;
    ti = 0;
    en_cnt = 0;
    rw_bad = 0;
    for (int c = 0; c <= 46; c++) begin
      if (valid_at_20 && c == 20) begin
        wr_if.i_wr_valid = 1'b1;
        wr_if.i_wr_rs    = 1'b1;
        wr_if.i_wr_data  = 8'h55;
      end
      if (lcd_en === 1'b1) en_cnt++;
      if (lcd_rw !== 1'b0) rw_bad++;
      if (ti < init_tbl.size() && init_tbl[ti].cyc == c) begin
        chk($sformatf("init c%0d en", c),   lcd_en,        init_tbl[ti].en);
        chk($sformatf("init c%0d data", c), lcd_data,      init_tbl[ti].data);
        chk($sformatf("init c%0d rs", c),   lcd_rs,        init_tbl[ti].rs);
        chk($sformatf("init c%0d rdy", c),  wr_if.o_wr_ready, init_tbl[ti].rdy);
        chk($sformatf("init c%0d done", c), init_done,     init_tbl[ti].done);
        chk($sformatf("init c%0d on", c),   lcd_on,        init_tbl[ti].on);
        ti++;
      end
      if (c != 46) step();
    end
    chk("init en_high_cycles", en_cnt, 8);
    chk("init rw_nonzero_cycles", rw_bad, 0);
  endtask

  // Called in a cycle with ready=1; returns in the cycle where ready is back.
  task automatic do_write(input logic rs, input logic [7:0] d, input int exp_lat);
    int lat;
    chk("wr start_ready", wr_if.o_wr_ready, 1'b1);
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_rs    = rs;
    wr_if.i_wr_data  = d;
    step();
    wr_if.i_wr_valid = 1'b0;
    chk($sformatf("wr %0h t+1 data", d), lcd_data, d);
    chk($sformatf("wr %0h t+1 rs", d), lcd_rs, rs);
    chk($sformatf("wr %0h t+1 en", d), lcd_en, 1'b0);
    chk($sformatf("wr %0h t+1 ready", d), wr_if.o_wr_ready, 1'b0);
    step();
    chk($sformatf("wr %0h t+2 en", d), lcd_en, 1'b1);
    step();
    chk($sformatf("wr %0h t+3 en", d), lcd_en, 1'b1);
    step();
    chk($sformatf("wr %0h t+4 en", d), lcd_en, 1'b0);
    chk($sformatf("wr %0h t+4 data", d), lcd_data, d);
    lat = 4;
    while (wr_if.o_wr_ready !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk($sformatf("wr rs%0d %0h latency", rs, d), lat, exp_lat);
  endtask

  initial begin
    int rises;
    int first_rise;
    int stab_bad;
    int lat;
    logic prev_en;
    logic [7:0] cur;

    n_checks = 0;
    n_errors = 0;

    init_tbl.push_back('{0,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    init_tbl.push_back('{1,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{7,  1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{8,  1'b0, 8'h38, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{9,  1'b1, 8'h38, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{10, 1'b1, 8'h38, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{11, 1'b0, 8'h38, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{16, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{17, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{18, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{19, 1'b0, 8'h0C, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{24, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{25, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{26, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{37, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{38, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{39, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{40, 1'b1, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{41, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{45, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 1'b1});
    init_tbl.push_back('{46, 1'b0, 8'h06, 1'b0, 1'b1, 1'b1, 1'b1});

    // Latency = 1 + SETUP + EN_HIGH + HOLD + wait: 9 for ordinary bytes, 15 for clear/home.
    wr_tbl.push_back('{1'b1, 8'h41, 9});
    wr_tbl.push_back('{1'b0, 8'h01, 15});
    wr_tbl.push_back('{1'b1, 8'h01, 9});
    wr_tbl.push_back('{1'b0, 8'h02, 15});
    wr_tbl.push_back('{1'b0, 8'h03, 15});
    wr_tbl.push_back('{1'b0, 8'h04, 9});
    wr_tbl.push_back('{1'b0, 8'h00, 9});

    // Clock and reset
    rst = 1'b1;
    wr_if.i_wr_valid = 1'b0;
    wr_if.i_wr_rs    = 1'b0;
    wr_if.i_wr_data  = 8'h00;
    repeat (4) step();
    chk("reset dbg_state", dbg_state, 3'd0);
    chk("reset ready", wr_if.o_wr_ready, 1'b0);
    rst = 1'b0;

    run_init(1'b0);

    foreach (wr_tbl[i]) do_write(wr_tbl[i].rs, wr_tbl[i].data, wr_tbl[i].lat);

    // Back-to-back: valid held high across two transfers
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h49);
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_rs    = 1'b1;
    wr_if.i_wr_data  = 8'h48;
    prev_en = lcd_en;
    rises = 0;
    first_rise = -1;
    stab_bad = 0;
    cur = 8'h00;
    for (int k = 1; k <= 25; k++) begin
      step();
      if (k == 1) wr_if.i_wr_data = 8'h49;
      if (k == 10) wr_if.i_wr_valid = 1'b0;
      if (lcd_en === 1'b1 && prev_en !== 1'b1) begin
        rises++;
        if (first_rise < 0) begin
          first_rise = k;
          chk("b2b first_en_rise", k, 2);
        end else begin
          chk("b2b en_spacing", k - first_rise, 9);
        end
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          chk("b2b en_data", lcd_data, cur);
        end else begin
          chk("b2b unexpected_pulse", rises, 2);
        end
      end
      if (lcd_en === 1'b1 && lcd_data !== cur) stab_bad++;
      prev_en = lcd_en;
    end
    chk("b2b pulse_count", rises, 2);
    chk("b2b data_unstable_cycles", stab_bad, 0);
    chk("b2b ready_after", wr_if.o_wr_ready, 1'b1);

    // Reset while EN is high
    wr_if.i_wr_valid = 1'b1;
    wr_if.i_wr_rs    = 1'b1;
    wr_if.i_wr_data  = 8'h5A;
    step();
    wr_if.i_wr_valid = 1'b0;
    step();
    chk("rst_mid en_before", lcd_en, 1'b1);
    rst = 1'b1;
    step();
    chk("rst_mid en", lcd_en, 1'b0);
    chk("rst_mid ready", wr_if.o_wr_ready, 1'b0);
    chk("rst_mid done", init_done, 1'b0);
    chk("rst_mid dbg_state", dbg_state, 3'd0);
    rst = 1'b0;

    // Re-init with valid raised at cycle 20; accepted only at edge 46
    run_init(1'b1);
    step();
    wr_if.i_wr_valid = 1'b0;
    chk("early_valid c47 data", lcd_data, 8'h55);
    chk("early_valid c47 rs", lcd_rs, 1'b1);
    chk("early_valid c47 ready", wr_if.o_wr_ready, 1'b0);
    step();
    chk("early_valid c48 en", lcd_en, 1'b1);
    lat = 2;
    while (wr_if.o_wr_ready !== 1'b1 && lat < 40) begin
      step();
      lat++;
    end
    chk("early_valid latency", lat, 9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
